ppu_render_sequencer: RTL and testbench

PPU_RENDER_SEQUENCER -- requirements
Module: ppu_render_sequencer

---
 rtl/ppu_render_sequencer.sv | 131 +++++++++++++
 tb/tb_ppu_render_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_render_sequencer.sv
// PPU render sequencer: dot/scanline timing generator for one PPU frame.
// Walks 341 dots x 262 scanlines, including the odd-frame short line. It
// decodes the position into the scroll, OAM and vblank strobes that the
// register handler consumes on the same clock edge.
//
// Ports
//   clk                 PPU master clock
//   rst_n               asynchronous active-low reset
//   clkEn               dot enable, one dot per enabled edge
//   background_EN       mask bit; rendering = background_EN | sprite_EN
//   sprite_EN           mask bit
//   dot [8:0]           current dot, 0..340
//   scanline [8:0]      current scanline, 0..261 (261 = pre-render)
//   frameOdd            frame parity
//   incrementX          coarse-X increment strobe
//   incrementY          fine/coarse-Y increment strobe
//   resetX              horizontal scroll reload strobe
//   resetY              vertical scroll reload strobe
//   setVerticalBlank    vblank flag set strobe at (241,1)
//   clearVerticalBlank  vblank flag clear strobe at (261,1)
//   oamReset            OAM address reset strobe
//   vblankActive        registered vblank level
//   frameStart          strobe at (0,0)
module ppu_render_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clkEn,
  input  logic       background_EN,
  input  logic       sprite_EN,
  output logic [8:0] dot,
  output logic [8:0] scanline,
  output logic       frameOdd,
  output logic       incrementX,
  output logic       incrementY,
  output logic       resetX,
  output logic       resetY,
  output logic       setVerticalBlank,
  output logic       clearVerticalBlank,
  output logic       oamReset,
  output logic       vblankActive,
  output logic       frameStart
);

  localparam logic [8:0] LastDot  = 9'd340;
  localparam logic [8:0] LastLine = 9'd261;

  logic [8:0] dot_q, dot_d;
  logic [8:0] line_q, line_d;
  logic       odd_q, odd_d;
  logic       vblank_q, vblank_d;
  // Set by reset so the (0,0) position reached by reset does not look like a
  // real frame start; cleared on the first enabled dot.
  logic       fresh_q, fresh_d;

  logic rendering;
  logic en;
  logic render_line;
  logic skip;
  logic fetch_dot;

  assign rendering   = background_EN | sprite_EN;
  // Strobes are suppressed while reset is held, even with clkEn high.
  assign en          = clkEn & rst_n;
  assign render_line = (line_q <= 9'd239) || (line_q == LastLine);
  assign skip        = (line_q == LastLine) && (dot_q == 9'd339) && odd_q && rendering;
  // Tile fetch boundaries: every 8th dot of the visible span plus the two
  // prefetch tiles for the next line.
  assign fetch_dot   = ((dot_q[2:0] == 3'd0) && (dot_q >= 9'd8) && (dot_q <= 9'd256)) ||
                       (dot_q == 9'd328) || (dot_q == 9'd336);

  always_comb begin
    incrementX         = en & rendering & render_line & fetch_dot;
    incrementY         = en & rendering & render_line & (dot_q == 9'd256);
    resetX             = en & rendering & render_line & (dot_q == 9'd257);
    resetY             = en & rendering & (line_q == LastLine) &
                         (dot_q >= 9'd280) & (dot_q <= 9'd304);
    oamReset           = en & rendering & render_line & (dot_q >= 9'd257) & (dot_q <= 9'd320);
    setVerticalBlank   = en & (line_q == 9'd241) & (dot_q == 9'd1);
    clearVerticalBlank = en & (line_q == LastLine) & (dot_q == 9'd1);
    frameStart         = en & ~fresh_q & (line_q == 9'd0) & (dot_q == 9'd0);
  end

  always_comb begin
    dot_d    = dot_q;
    line_d   = line_q;
    odd_d    = odd_q;
    vblank_d = vblank_q;
    fresh_d  = fresh_q;
    if (clkEn) begin
      fresh_d = 1'b0;
      if (skip || (dot_q == LastDot)) begin
        dot_d = 9'd0;
        if (skip || (line_q == LastLine)) begin
          line_d = 9'd0;
          odd_d  = ~odd_q;
        end else begin
          line_d = line_q + 9'd1;
        end
      end else begin
        dot_d = dot_q + 9'd1;
      end
      if (setVerticalBlank) begin
        vblank_d = 1'b1;
      end else if (clearVerticalBlank) begin
        vblank_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dot_q    <= 9'd0;
      line_q   <= 9'd0;
      odd_q    <= 1'b0;
      vblank_q <= 1'b0;
      fresh_q  <= 1'b1;
    end else begin
      dot_q    <= dot_d;
      line_q   <= line_d;
      odd_q    <= odd_d;
      vblank_q <= vblank_d;
      fresh_q  <= fresh_d;
    end
  end

  assign dot          = dot_q;
  assign scanline     = line_q;
  assign frameOdd     = odd_q;
  assign vblankActive = vblank_q;

endmodule

// File: tb/tb_ppu_render_sequencer.sv
// Directed bench for ppu_render_sequencer: reset values, frame lengths with
// and without the odd-frame skip, per-line strobe tallies, clock-enable
// gating, mid-line mask changes and asynchronous reset mid-frame.
module tb_ppu_render_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clkEn;
  logic       background_EN;
  logic       sprite_EN;
  logic [8:0] dot;
  logic [8:0] scanline;
  logic       frameOdd;
  logic       incrementX;
  logic       incrementY;
  logic       resetX;
  logic       resetY;
  logic       setVerticalBlank;
  logic       clearVerticalBlank;
  logic       oamReset;
  logic       vblankActive;
  logic       frameStart;

  int n_total = 0;
  int n_bad   = 0;

  // Strobe tallies gathered by cycle().
  int ix_l0_n, ix_l0_sum, iy_l0_n, iy_l0_dot, rx_l0_n, rx_l0_dot, oam_l0_n, oam_l0_sum;
  int ix_all_n, ix_vbl_n, ry_261_n, ry_261_sum, ry_other_n;
  int svb_n, svb_line, svb_dot, cvb_n, cvb_line, cvb_dot, fs_n, off_bad_n;
  int vb_241_1, vb_241_2, vb_261_1, vb_261_2;
  int d0, d1;

  always #5 clk = ~clk;

  ppu_render_sequencer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .clkEn              (clkEn),
    .background_EN      (background_EN),
    .sprite_EN          (sprite_EN),
    .dot                (dot),
    .scanline           (scanline),
    .frameOdd           (frameOdd),
    .incrementX         (incrementX),
    .incrementY         (incrementY),
    .resetX             (resetX),
    .resetY             (resetY),
    .setVerticalBlank   (setVerticalBlank),
    .clearVerticalBlank (clearVerticalBlank),
    .oamReset           (oamReset),
    .vblankActive       (vblankActive),
    .frameStart         (frameStart)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] strobes();
    return {incrementX, incrementY, resetX, resetY, setVerticalBlank, clearVerticalBlank,
            oamReset, frameStart};
  endfunction

  task automatic clear_tally();
    ix_l0_n = 0; ix_l0_sum = 0; iy_l0_n = 0; iy_l0_dot = -1; rx_l0_n = 0; rx_l0_dot = -1;
    oam_l0_n = 0; oam_l0_sum = 0; ix_all_n = 0; ix_vbl_n = 0;
    ry_261_n = 0; ry_261_sum = 0; ry_other_n = 0;
    svb_n = 0; svb_line = -1; svb_dot = -1; cvb_n = 0; cvb_line = -1; cvb_dot = -1;
    fs_n = 0; off_bad_n = 0;
    vb_241_1 = -1; vb_241_2 = -1; vb_261_1 = -1; vb_261_2 = -1;
  endtask

  // Called 1 time unit after a rising edge: sample mid-cycle, then advance.
  task automatic cycle();
    #2;
    if (incrementX) ix_all_n++;
    if (incrementX && scanline >= 9'd240 && scanline <= 9'd260) ix_vbl_n++;
    if (scanline == 9'd0) begin
      if (incrementX) begin ix_l0_n++; ix_l0_sum += int'(dot); end
      if (incrementY) begin iy_l0_n++; iy_l0_dot = int'(dot); end
      if (resetX)     begin rx_l0_n++; rx_l0_dot = int'(dot); end
      if (oamReset)   begin oam_l0_n++; oam_l0_sum += int'(dot); end
    end
    if (resetY) begin
      if (scanline == 9'd261) begin ry_261_n++; ry_261_sum += int'(dot); end
      else ry_other_n++;
    end
    if (setVerticalBlank)   begin svb_n++; svb_line = int'(scanline); svb_dot = int'(dot); end
    if (clearVerticalBlank) begin cvb_n++; cvb_line = int'(scanline); cvb_dot = int'(dot); end
    if (frameStart) fs_n++;
    if (!clkEn && strobes() != 8'd0) off_bad_n++;
    if (scanline == 9'd241 && dot == 9'd1) vb_241_1 = int'(vblankActive);
    if (scanline == 9'd241 && dot == 9'd2) vb_241_2 = int'(vblankActive);
    if (scanline == 9'd261 && dot == 9'd1) vb_261_1 = int'(vblankActive);
    if (scanline == 9'd261 && dot == 9'd2) vb_261_2 = int'(vblankActive);
    @(posedge clk);
    #1;
  endtask

  // Counts enabled dots from (0,0) until the next return to (0,0).
  task automatic run_frame(output int dots);
    dots = 0;
    do begin
      if (clkEn) dots++;
      cycle();
    end while (!(dot == 9'd0 && scanline == 9'd0) && dots < 90000);
  endtask

  task automatic goto_pos(input int ln, input int dt);
    int n;
    n = 0;
    clkEn = 1'b1;
    while (!(int'(scanline) == ln && int'(dot) == dt) && n < 100000) begin
      cycle();
      n++;
    end
    check_eq("goto_line", {23'd0, scanline}, ln);
    check_eq("goto_dot", {23'd0, dot}, dt);
  endtask

  initial begin
    rst_n         = 1'b0;
    clkEn         = 1'b1;
    background_EN = 1'b1;
    sprite_EN     = 1'b0;
    clear_tally();
    repeat (3) @(posedge clk);
    #1;

    // Held in reset with clkEn and rendering high.
    check_eq("rst_dot", {23'd0, dot}, 0);
    check_eq("rst_line", {23'd0, scanline}, 0);
    check_eq("rst_odd", {31'd0, frameOdd}, 0);
    check_eq("rst_vblank", {31'd0, vblankActive}, 0);
    check_eq("rst_strobes", {24'd0, strobes()}, 0);

    // Frame 0, rendering off: full 341x262 frame.
    background_EN = 1'b0;
    rst_n         = 1'b1;
    #1;
    check_eq("fs_after_reset", {31'd0, frameStart}, 0);
    clear_tally();
    run_frame(d0);
    check_eq("f0_len", d0, 89342);
    check_eq("f0_end_line", {23'd0, scanline}, 0);
    check_eq("f0_end_dot", {23'd0, dot}, 0);
    check_eq("f0_odd", {31'd0, frameOdd}, 1);
    check_eq("f0_fs_count", fs_n, 0);
    check_eq("f0_fs_now", {31'd0, frameStart}, 1);
    check_eq("f0_svb_n", svb_n, 1);
    check_eq("f0_svb_pos", svb_line * 1000 + svb_dot, 241001);
    check_eq("f0_cvb_n", cvb_n, 1);
    check_eq("f0_cvb_pos", cvb_line * 1000 + cvb_dot, 261001);
    check_eq("vb_241_1", vb_241_1, 0);
    check_eq("vb_241_2", vb_241_2, 1);
    check_eq("vb_261_1", vb_261_1, 1);
    check_eq("vb_261_2", vb_261_2, 0);
    check_eq("f0_ix_off", ix_all_n, 0);
    check_eq("f0_ry_off", ry_261_n + ry_other_n, 0);

    // Frame 1, rendering on, odd: dot 340 of line 261 is skipped.
    background_EN = 1'b1;
    clear_tally();
    run_frame(d1);
    check_eq("f1_len", d1, 89341);
    check_eq("f1_odd", {31'd0, frameOdd}, 0);
    check_eq("f1_fs_count", fs_n, 1);
    check_eq("l0_ix_n", ix_l0_n, 34);
    check_eq("l0_ix_sum", ix_l0_sum, 4888);
    check_eq("l0_iy_n", iy_l0_n, 1);
    check_eq("l0_iy_dot", iy_l0_dot, 256);
    check_eq("l0_rx_n", rx_l0_n, 1);
    check_eq("l0_rx_dot", rx_l0_dot, 257);
    check_eq("l0_oam_n", oam_l0_n, 64);
    check_eq("l0_oam_sum", oam_l0_sum, 18464);
    check_eq("ry_261_n", ry_261_n, 25);
    check_eq("ry_261_sum", ry_261_sum, 7300);
    check_eq("ry_other_n", ry_other_n, 0);
    check_eq("ix_vblank_lines", ix_vbl_n, 0);
    check_eq("f1_svb_n", svb_n, 1);

    // Clock-enable gating at line 10.
    goto_pos(10, 96);
    clear_tally();
    clkEn = 1'b0;
    #1;
    check_eq("ix_gated", {31'd0, incrementX}, 0);
    cycle();
    check_eq("dot_hold", {23'd0, dot}, 96);
    clkEn = 1'b1;
    #1;
    check_eq("ix_96", {31'd0, incrementX}, 1);
    cycle();
    for (int i = 0; i < 6; i++) begin
      clkEn = (i % 2 == 1);
      cycle();
    end
    check_eq("toggle_dot", {23'd0, dot}, 100);
    check_eq("toggle_line", {23'd0, scanline}, 10);
    check_eq("off_strobes", off_bad_n, 0);

    // Mask dropped at (10,100): no fetch strobe at (10,104).
    background_EN = 1'b0;
    goto_pos(10, 104);
    #1;
    check_eq("ix_dropped", {31'd0, incrementX}, 0);
    // Sprite mask alone re-enables rendering.
    sprite_EN = 1'b1;
    goto_pos(10, 112);
    #1;
    check_eq("ix_resume_sprite", {31'd0, incrementX}, 1);

    // Asynchronous reset mid-frame.
    background_EN = 1'b1;
    sprite_EN     = 1'b0;
    goto_pos(150, 200);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_dot", {23'd0, dot}, 0);
    check_eq("arst_line", {23'd0, scanline}, 0);
    check_eq("arst_odd", {31'd0, frameOdd}, 0);
    check_eq("arst_vblank", {31'd0, vblankActive}, 0);
    check_eq("arst_strobes", {24'd0, strobes()}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clkEn = 1'b1;
    cycle();
    check_eq("post_rst_line", {23'd0, scanline}, 0);
    check_eq("post_rst_dot", {23'd0, dot}, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
